// File: rtl/bla_serial_sub.sv
// rtl/bla_serial_sub.sv - digit-serial subtractor, 4 bits per clock with borrow look-ahead per digit
// Optional signed-overflow output enabled by defining BLA_OVF_EN.
module bla_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef BLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic [WIDTH-1:0] a_r, b_r, diff_r;
    logic             bout_r;
    logic             last;

    logic [3:0]       da, db, g, p, d;
    logic [4:0]       c;
    logic [WIDTH-1:0] a_shf, b_shf, diff_shf;

`ifdef BLA_OVF_EN
    logic             sa, sb, ovf_r;
`endif

    assign last      = (cnt == CW'(NDIG - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;
`ifdef BLA_OVF_EN
    assign ovf       = ovf_r;
`endif

    // Operands shift right each RUN cycle, so the active digit is always bits [3:0];
    // result digits enter at the top and settle into place after NDIG shifts.
    always_comb begin
        da = a_r[3:0];
        db = b_r[3:0];
        g  = ~da & db;
        p  = ~(da ^ db);
        c[0] = brw;
        c[1] = g[0] | (p[0] & brw);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & brw);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & brw);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & brw);
        d        = da ^ db ^ c[3:0];
        a_shf    = a_r >> 4;
        b_shf    = b_r >> 4;
        diff_shf = (diff_r >> 4) | (WIDTH'(d) << (WIDTH - 4));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            brw    <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
`ifdef BLA_OVF_EN
            sa     <= 1'b0;
            sb     <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        brw    <= bin;
                        cnt    <= '0;
                        diff_r <= '0;
`ifdef BLA_OVF_EN
                        sa     <= a[WIDTH-1];
                        sb     <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_r    <= a_shf;
                    b_r    <= b_shf;
                    diff_r <= diff_shf;
                    brw    <= c[4];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bout_r <= c[4];
`ifdef BLA_OVF_EN
                        ovf_r  <= (sa != sb) & (diff_shf[WIDTH-1] != sa);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bla_serial_sub.sv
// tb/tb_bla_serial_sub.sv - randomized scoreboard bench for bla_serial_sub
module tb_bla_serial_sub;

    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef BLA_OVF_EN
    logic             ovf;
`endif

    bla_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .bin(bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff(diff),
        .bout(bout)
`ifdef BLA_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        time              acc_t;
    } exp_t;

    exp_t sbq[$];
    int   total  = 0;
    int   passed = 0;
    bit   hold_rdy  = 1'b0;
    bit   rst_phase = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Plain integer arithmetic: unsigned difference, borrow, and signed range test.
    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                   input logic tbin, input time t);
        exp_t   e;
        longint ua, ub, sa, sb, sd;
        ua = longint'(ta);
        ub = longint'(tb) + longint'(tbin);
        e.diff = WIDTH'(ua - ub);
        e.bout = (ua < ub);
        sa = ta[WIDTH-1] ? ua - (64'sd1 <<< WIDTH) : ua;
        sb = tb[WIDTH-1] ? longint'(tb) - (64'sd1 <<< WIDTH) : longint'(tb);
        sd = sa - sb;
        e.ovf = (sd < -(64'sd1 <<< (WIDTH - 1))) || (sd > (64'sd1 <<< (WIDTH - 1)) - 1);
        e.acc_t = t;
        return e;
    endfunction

    // Monitor: drives out_ready, compares the held result every DONE cycle, pops on handshake.
    initial begin
        bit prev = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_phase) begin
                prev = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    if (!prev) chk("latency", 64'(($time - 5 - sbq[0].acc_t) / 10), NDIG);
                    chk("diff", diff, sbq[0].diff);
                    chk("bout", bout, sbq[0].bout);
`ifdef BLA_OVF_EN
                    chk("ovf", ovf, sbq[0].ovf);
`endif
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
            prev = out_valid;
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
        int n = 0;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sbq.push_back(model(ta, tb, tbin, $time));
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
`ifdef BLA_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1 rst_phase = 1'b0;

        send(16'h1234, 16'h0034, 1'b0);
        send(16'h0000, 16'h0001, 1'b0);
        send(16'h5A5A, 16'h5A5A, 1'b1);
        send(16'h5A5A, 16'h5A5A, 1'b0);
        send(16'h8000, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        send(16'h0000, 16'hFFFF, 1'b1);
        send(16'h7FFF, 16'h8000, 1'b0);
        wait_drain();

        // Backpressure with new operands offered while DONE is held.
        hold_rdy = 1'b1;
        send(16'hC3A5, 16'h1F2E, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            in_valid = 1'b1;
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        hold_rdy = 1'b0;
        n = 0;
        while (out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_drained", 64'(sbq.size()), 0);
        send(16'h4321, 16'h1234, 1'b0);
        wait_drain();

        // Reset in the middle of RUN.
        send(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_phase = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bout", bout, 0);
        chk("midrst_in_ready", in_ready, 1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 rst_phase = 1'b0;
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_drain();

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end
        wait_drain();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
